aes_block_serializer: RTL and testbench
=======================================

Name: aes_block_serializer

Overview:
- Output-side counterpart of the stream engine input path: takes 128-bit AES result blocks from the cipher core and serializes each block into 32-bit words on an HWPE source stream toward the output streamer.
- Per-job block counter, busy/done flags for the controller FSM, and back-to-back block acceptance, so a fully-ready sink sees one word per cycle.

Parameters:
- DATA_WIDTH, 32, output stream word width in bits.
- BLOCK_WIDTH, 128, input block width in bits; must be an integer multiple of DATA_WIDTH.
- NWORDS, BLOCK_WIDTH/DATA_WIDTH, words per block; derived, not overridable.
- WORD_ORDER, 1, word emission order:
  - 1: bits [BLOCK_WIDTH-1 -: DATA_WIDTH] first (AES big-endian state order).
  - 0: bits [DATA_WIDTH-1:0] first.
- CNT_WIDTH, 16, width of the block counters.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  job start pulse; honoured only in IDLE.
- clear_i  in  1  synchronous abort/clear.
- nblocks_i  in  CNT_WIDTH  blocks in the job; sampled on accepted start.
- blk_data_i  in  BLOCK_WIDTH  result block from the cipher core.
- blk_valid_i  in  1  block valid.
- blk_ready_o  out  1  block accepted when high together with blk_valid_i.
- d_o  source  hwpe_stream_intf_stream (DATA_WIDTH)  output word stream; uses data, valid, ready and strb.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job completion.
- blk_cnt_o  out  CNT_WIDTH  blocks fully emitted in the current job.

Behaviour:
- Reset (rst_i high, asynchronous):
  - state=IDLE.
  - d_o.valid=0, d_o.data=0, blk_ready_o=0, busy_o=0, done_o=0, blk_cnt_o=0.
  - Holding register and word index cleared.
- States: IDLE, ACCEPT, SEND, DONE.
- IDLE:
  - start_i=1: latch nblocks_i, clear blk_cnt, go to ACCEPT.
  - If nblocks_i==0: go to DONE instead; no words are emitted.
- ACCEPT:
  - blk_ready_o=1.
  - On blk_valid_i&&blk_ready_o: latch blk_data_i into the holding register, word index=0, go to SEND.
- SEND:
  - d_o.valid=1; d_o.data = holding word at index per WORD_ORDER; d_o.strb all ones.
  - d_o.data and d_o.valid stay stable while d_o.ready=0 (no retraction, no change).
  - On a handshake with index<NWORDS-1: index increments.
  - On a handshake on the last word (index==NWORDS-1):
    - blk_cnt increments.
    - If the new count equals the latched nblocks: go to DONE.
    - Otherwise blk_ready_o=1 combinationally in the same cycle. If blk_valid_i=1, the new block is latched, index=0 and the state stays SEND (zero-bubble). If blk_valid_i=0, go to ACCEPT.
  - blk_ready_o=0 at every other point in SEND.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o=0 in DONE and IDLE; busy_o=1 in ACCEPT and SEND.
- Latency and throughput:
  - First word is valid the cycle after block acceptance.
  - With d_o.ready held at 1: NWORDS cycles per block, no gap between blocks.
- blk_cnt_o:
  - Holds its final value after DONE until the next accepted start or clear_i.
  - Counts modulo 2^CNT_WIDTH, which cannot wrap within a legal job.
- start_i outside IDLE is ignored; latched nblocks is unaffected.
- clear_i=1 (any state) has priority over all other events in that cycle:
  - Next cycle: IDLE, d_o.valid=0, blk_cnt=0, index=0, no done_o pulse.
  - A word in flight is dropped.
- rst_i asserted mid-job: immediate return to reset values; no outputs glitch high after release.
- blk_valid_i while not ready: block not consumed; the upstream holds it.

Test Plan:
- Reset, then start_i with nblocks_i=1, block 0x00112233_44556677_8899AABB_CCDDEEFF, d_o.ready=1:
  - Words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles.
  - done_o pulses one cycle later; blk_cnt_o=1.
- Same block with WORD_ORDER=0: order 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
- nblocks_i=3, blk_valid_i always high, d_o.ready=1: 12 consecutive valid words, blk_ready_o high on cycles 4 and 8 of the SEND stream, then done_o; busy_o high throughout.
- Random d_o.ready backpressure (≈50%) over 4 blocks: data stable whenever valid&&!ready; all 16 words in order, no duplicates, blk_cnt_o=4.
- start_i with nblocks_i=0: no d_o.valid, done_o pulses one cycle after start, blk_cnt_o=0.
- Abort and reset mid-job:
  - clear_i during word 2 of block 2 of 4: next cycle d_o.valid=0, busy_o=0, blk_cnt_o=0, no done_o. A fresh start then emits correctly.
  - Repeat with rst_i instead of clear_i: outputs reset immediately, asynchronously.

Source files
------------

// File: rtl/aes_block_serializer_if.sv
// HWPE-style word stream: data/strb qualified by valid, consumed when valid && ready.
// The source holds data and valid stable until ready is seen; valid is never retracted.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_block_serializer.sv
// Serializes 128-bit AES result blocks into DATA_WIDTH words on an HWPE source stream,
// counting blocks per job and flagging busy/done for the controller.
module aes_block_serializer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned WORD_ORDER  = 1,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned NWORDS     = BLOCK_WIDTH / DATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [CNT_WIDTH-1:0]   nblocks_i,
  input  logic [BLOCK_WIDTH-1:0] blk_data_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  hwpe_stream_intf_stream.source d_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   blk_cnt_o
);

  localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_SEND   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [BLOCK_WIDTH-1:0] r_hold;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_nblk;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_last;
  logic                   w_blk_ready;
  logic                   w_load;
  logic                   w_start;
  logic                   w_idx_inc;
  logic                   w_cnt_inc;
  logic [DATA_WIDTH-1:0]  w_words [NWORDS];

  assign w_last    = (r_idx == LAST_IDX);
  assign w_cnt_nxt = r_cnt + CNT_WIDTH'(1);

  // Word table in emission order, so the stream simply walks index 0..NWORDS-1.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      w_words[i] = (WORD_ORDER != 0) ? r_hold[BLOCK_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH]
                                     : r_hold[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blk_ready = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_idx_inc   = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start     = 1'b1;
          w_state_nxt = (nblocks_i == '0) ? S_DONE : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_blk_ready = 1'b1;
        if (blk_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (d_o.ready) begin
          if (!w_last) begin
            w_idx_inc = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
            if (w_cnt_nxt == r_nblk) begin
              w_state_nxt = S_DONE;
            end else begin
              // Take the next block in the same cycle as the last word: no bubble.
              w_blk_ready = 1'b1;
              if (blk_valid_i) w_load = 1'b1;
              else             w_state_nxt = S_ACCEPT;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clear_i) begin
      w_state_nxt = S_IDLE;
      w_blk_ready = 1'b0;
      w_load      = 1'b0;
      w_start     = 1'b0;
      w_idx_inc   = 1'b0;
      w_cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_nblk  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clear_i) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else begin
        if (w_start) begin
          r_nblk <= nblocks_i;
          r_cnt  <= '0;
        end
        if (w_load) begin
          r_hold <= blk_data_i;
          r_idx  <= '0;
        end else if (w_idx_inc) begin
          r_idx <= r_idx + IDX_W'(1);
        end
        if (w_cnt_inc) r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign d_o.valid   = (r_state == S_SEND);
  assign d_o.data    = w_words[r_idx];
  assign d_o.strb    = '1;
  assign blk_ready_o = w_blk_ready;
  assign busy_o      = (r_state == S_ACCEPT) || (r_state == S_SEND);
  assign done_o      = (r_state == S_DONE);
  assign blk_cnt_o   = r_cnt;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed-plus-random bench: one instance per word order, a block source, and a word
// scoreboard whose expected words are sliced straight from each block's bit positions.
module tb_aes_block_serializer;

  localparam int DW = 32;
  localparam int BW = 128;
  localparam int NW = BW / DW;
  localparam int CW = 16;
  localparam logic [BW-1:0] KBLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0;
  logic          start1;
  logic          clear;
  logic [CW-1:0] nblocks;
  logic [BW-1:0] blk_data;
  logic          blk_valid;
  logic          d_ready;
  logic          blk_ready0, blk_ready1, busy0, busy1, done0, done1;
  logic [CW-1:0] cnt0, cnt1;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) d0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) d1 ();
  assign d0.ready = d_ready;
  assign d1.ready = d_ready;

  aes_block_serializer #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .WORD_ORDER(1), .CNT_WIDTH(CW)) u_dut_be (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .clear_i(clear), .nblocks_i(nblocks),
    .blk_data_i(blk_data), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready0), .d_o(d0),
    .busy_o(busy0), .done_o(done0), .blk_cnt_o(cnt0)
  );

  aes_block_serializer #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .WORD_ORDER(0), .CNT_WIDTH(CW)) u_dut_le (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .clear_i(clear), .nblocks_i(nblocks),
    .blk_data_i(blk_data), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready1), .d_o(d1),
    .busy_o(busy1), .done_o(done1), .blk_cnt_o(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  int            r_hs, r_done_n, r_done_cyc, r_first_v, r_last_hs, r_acc_first, r_busy_low, r_valid_n;
  int            r_rdy_pos[$];
  logic [CW-1:0] r_cnt_at_done;
  logic          r_busy_at_done;
  bit            r_fin;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: order 1 emits the most significant word first, order 0 the least.
  task automatic add_block(input logic [BW-1:0] b, input int order);
    logic [BW-1:0] sh;
    src_q.push_back(b);
    for (int k = 0; k < NW; k++) begin
      sh = (order != 0) ? (b >> (BW - DW * (k + 1))) : (b >> (DW * k));
      exp_q.push_back(sh[DW-1:0]);
    end
  endtask

  task automatic drive_src(input int pct);
    blk_valid = (src_q.size() > 0);
    blk_data  = blk_valid ? src_q[0] : '0;
    d_ready   = ($urandom_range(0, 99) < pct);
  endtask

  // Entered and left at posedge+1. abort_kind 0 = clear_i, 1 = rst_i, applied once
  // abort_at words have been accepted by the sink.
  task automatic run_job(input int sel, input int nblk, input int pct, input int abort_at, input int abort_kind);
    logic v, br, bs, dn, acc, hs, prev_stall;
    logic [DW-1:0] dat, prev_dat;
    logic [DW/8-1:0] sb;
    logic [CW-1:0] cn;
    int ab_phase;
    r_hs = 0; r_done_n = 0; r_done_cyc = -1; r_first_v = -1; r_last_hs = -1;
    r_acc_first = -1; r_busy_low = 0; r_valid_n = 0; r_rdy_pos.delete(); r_fin = 0;
    prev_stall = 1'b0; prev_dat = '0; ab_phase = 0;
    nblocks = CW'(nblk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    drive_src(pct);
    for (int i = 0; i < 400 && !r_fin; i++) begin
      @(negedge clk);
      v  = (sel != 0) ? d1.valid   : d0.valid;
      dat = (sel != 0) ? d1.data   : d0.data;
      sb = (sel != 0) ? d1.strb    : d0.strb;
      br = (sel != 0) ? blk_ready1 : blk_ready0;
      bs = (sel != 0) ? busy1      : busy0;
      dn = (sel != 0) ? done1      : done0;
      cn = (sel != 0) ? cnt1       : cnt0;
      if (ab_phase == 2) begin
        chk("abort_valid", v, 0);
        chk("abort_busy", bs, 0);
        chk("abort_cnt", cn, 0);
        chk("abort_done", dn, 0);
        r_fin = 1;
      end
      if (prev_stall) begin
        chk("stall_valid_held", v, 1);
        chk("stall_data_held", dat, prev_dat);
      end
      hs  = v && d_ready && !clear;
      acc = blk_valid && br;
      if (v) begin
        r_valid_n++;
        if (r_first_v < 0) r_first_v = i;
        if (br) r_rdy_pos.push_back(i - r_first_v + 1);
        chk("strb", sb, {(DW/8){1'b1}});
      end
      if (acc && r_acc_first < 0) r_acc_first = i;
      if (i >= 1 && r_done_n == 0 && !dn && !bs && nblk != 0 && ab_phase == 0) r_busy_low++;
      if (hs) begin
        if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
        else                   chk("word", dat, exp_q.pop_front());
        r_hs++;
        r_last_hs = i;
      end
      if (dn) begin
        r_done_n++;
        if (r_done_cyc < 0) begin
          r_done_cyc = i; r_cnt_at_done = cn; r_busy_at_done = bs;
        end
      end
      prev_stall = v && !d_ready && !clear;
      prev_dat   = dat;
      if (r_done_cyc >= 0 && i == r_done_cyc + 1) r_fin = 1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (acc) void'(src_q.pop_front());
      if (ab_phase == 1) begin
        clear = 1'b0;
        ab_phase = 2;
      end
      if (abort_at >= 0 && ab_phase == 0 && r_hs == abort_at) begin
        if (abort_kind == 0) begin
          clear = 1'b1;
          ab_phase = 1;
        end else begin
          rst = 1'b1;
          #1;
          chk("rst_async_valid", (sel != 0) ? d1.valid : d0.valid, 0);
          chk("rst_async_data", (sel != 0) ? d1.data : d0.data, 0);
          chk("rst_async_busy", (sel != 0) ? busy1 : busy0, 0);
          chk("rst_async_cnt", (sel != 0) ? cnt1 : cnt0, 0);
          chk("rst_async_blk_ready", (sel != 0) ? blk_ready1 : blk_ready0, 0);
          #1;
          rst = 1'b0;
          ab_phase = 2;
        end
      end
      drive_src(pct);
    end
    chk("job_finished", r_fin, 1);
    if (abort_at >= 0) begin
      src_q.delete();
      exp_q.delete();
    end
    blk_valid = 1'b0;
    blk_data  = '0;
    clear     = 1'b0;
  endtask

  task automatic check_normal_job(input string tag, input int nblk, input int full_rate);
    chk({tag, "_words"}, r_hs, nblk * NW);
    chk({tag, "_exp_empty"}, exp_q.size(), 0);
    chk({tag, "_done_pulses"}, r_done_n, 1);
    chk({tag, "_cnt_at_done"}, r_cnt_at_done, nblk);
    chk({tag, "_busy_in_done"}, r_busy_at_done, 0);
    chk({tag, "_busy_gaps"}, r_busy_low, 0);
    if (nblk > 0) begin
      chk({tag, "_first_latency"}, r_first_v, r_acc_first + 1);
      chk({tag, "_done_after_last"}, r_done_cyc, r_last_hs + 1);
    end
    if (full_rate != 0 && nblk > 0) chk({tag, "_no_gaps"}, r_last_hs - r_first_v, nblk * NW - 1);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; clear = 1'b0; nblocks = '0;
    blk_data = '0; blk_valid = 1'b0; d_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_be", d0.valid, 0);
    chk("reset_data_be", d0.data, 0);
    chk("reset_blk_ready_be", blk_ready0, 0);
    chk("reset_busy_be", busy0, 0);
    chk("reset_done_be", done0, 0);
    chk("reset_cnt_be", cnt0, 0);
    chk("reset_valid_le", d1.valid, 0);
    chk("reset_busy_le", busy1, 0);
    chk("reset_cnt_le", cnt1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known block, big-endian word order.
    add_block(KBLK, 1);
    run_job(0, 1, 100, -1, 0);
    check_normal_job("be_single", 1, 1);
    repeat (2) @(negedge clk);
    chk("cnt_holds_after_done", cnt0, 1);
    @(posedge clk);
    #1;

    // Same block, little-endian word order.
    add_block(KBLK, 0);
    run_job(1, 1, 100, -1, 0);
    check_normal_job("le_single", 1, 1);

    // Three back-to-back blocks at full rate.
    for (int b = 0; b < 3; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 3, 100, -1, 0);
    check_normal_job("b2b", 3, 1);
    chk("b2b_valid_cycles", r_valid_n, 12);
    chk("b2b_rdy_count", r_rdy_pos.size(), 2);
    if (r_rdy_pos.size() == 2) begin
      chk("b2b_rdy_first", r_rdy_pos[0], 4);
      chk("b2b_rdy_second", r_rdy_pos[1], 8);
    end

    // Random sink backpressure, both word orders.
    for (int b = 0; b < 4; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 4, 50, -1, 0);
    check_normal_job("bp_be", 4, 0);
    for (int b = 0; b < 4; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 0);
    run_job(1, 4, 50, -1, 0);
    check_normal_job("bp_le", 4, 0);

    // Empty job.
    run_job(0, 0, 100, -1, 0);
    check_normal_job("empty", 0, 0);
    chk("empty_no_valid", r_valid_n, 0);
    chk("empty_done_cycle", r_done_cyc, 1);

    // Abort with clear_i during word 2 of block 2, then a fresh job.
    for (int b = 0; b < 4; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 4, 100, 5, 0);
    chk("clear_words_before", r_hs, 5);
    chk("clear_no_done", r_done_n, 0);
    add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 1, 100, -1, 0);
    check_normal_job("after_clear", 1, 1);

    // Same abort point with rst_i, then a fresh job under backpressure.
    for (int b = 0; b < 4; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 4, 100, 5, 1);
    chk("rst_words_before", r_hs, 5);
    chk("rst_no_done", r_done_n, 0);
    for (int b = 0; b < 2; b++) add_block({$urandom, $urandom, $urandom, $urandom}, 1);
    run_job(0, 2, 60, -1, 0);
    check_normal_job("after_rst", 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
